// File: rtl/decode_stage.sv
// RV32I decode stage: registers decoded fields for execute, drives the register-file
// read port, and folds snooped register-file writes into the held operands.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_rs_ren,
   output logic [4:0]      o_rs1_raddr,
   output logic [4:0]      o_rs2_raddr,
   input  logic [XLEN-1:0] i_rs1_rdata,
   input  logic [XLEN-1:0] i_rs2_rdata,
   input  logic            i_rd_wvalid,
   input  logic [4:0]      i_rd_waddr,
   input  logic [XLEN-1:0] i_rd_wdata,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [4:0]      o_rd,
   output logic            o_rd_we,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_kind_t;

   logic            accept;
   logic            stall;
   logic            valid_reg;
   logic [XLEN-1:0] pc_reg;
   logic [6:0]      opcode_reg;
   logic [2:0]      funct3_reg;
   logic [6:0]      funct7_reg;
   logic [4:0]      rd_reg;
   logic            rd_we_reg;
   logic [4:0]      rs1_addr_reg;
   logic [4:0]      rs2_addr_reg;
   logic [XLEN-1:0] imm_reg;
   logic            illegal_reg;

   imm_kind_t       imm_kind;
   logic            writes_rd;
   logic            legal;
   logic [XLEN-1:0] imm_next;
   logic            rd_we_next;

   logic [4:0]      raddr [2];
   logic [4:0]      held_addr [2];
   logic [XLEN-1:0] rdata [2];
   logic [XLEN-1:0] operand [2];

   assign o_ready     = !valid_reg || i_ready;
   assign accept      = i_valid && o_ready && !i_flush;
   assign o_rs_ren    = i_valid && o_ready;
   assign stall       = valid_reg && !i_ready;
   assign o_rs1_raddr = i_instr[19:15];
   assign o_rs2_raddr = i_instr[24:20];

   always_comb begin
      imm_kind  = IMM_NONE;
      writes_rd = 1'b0;
      legal     = 1'b1;
      case (i_instr[6:0])
         OP_LUI, OP_AUIPC:         begin imm_kind = IMM_U; writes_rd = 1'b1; end
         OP_JAL:                   begin imm_kind = IMM_J; writes_rd = 1'b1; end
         OP_JALR, OP_LOAD, OP_IMM: begin imm_kind = IMM_I; writes_rd = 1'b1; end
         OP_SYSTEM:                imm_kind = IMM_I;
         OP_BRANCH:                imm_kind = IMM_B;
         OP_STORE:                 imm_kind = IMM_S;
         OP_OP:                    writes_rd = 1'b1;
         OP_MISC:                  imm_kind = IMM_NONE;
         default:                  legal = 1'b0;
      endcase
      if (i_instr[1:0] != 2'b11) begin
         legal = 1'b0;
      end
      // Illegal instructions still flow downstream, but inert.
      if (!legal) begin
         imm_kind  = IMM_NONE;
         writes_rd = 1'b0;
      end
   end

   always_comb begin
      imm_next = '0;
      case (imm_kind)
         IMM_I:   imm_next = {{(XLEN-11){i_instr[31]}}, i_instr[30:20]};
         IMM_S:   imm_next = {{(XLEN-11){i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
         IMM_B:   imm_next = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   imm_next = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
         IMM_J:   imm_next = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: imm_next = '0;
      endcase
   end

   assign rd_we_next = writes_rd && (i_instr[11:7] != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg    <= 1'b0;
         pc_reg       <= '0;
         opcode_reg   <= '0;
         funct3_reg   <= '0;
         funct7_reg   <= '0;
         rd_reg       <= '0;
         rd_we_reg    <= 1'b0;
         rs1_addr_reg <= '0;
         rs2_addr_reg <= '0;
         imm_reg      <= '0;
         illegal_reg  <= 1'b0;
      end else begin
         if (i_flush) begin
            valid_reg <= 1'b0;
         end else if (accept) begin
            valid_reg <= 1'b1;
         end else if (i_ready) begin
            valid_reg <= 1'b0;
         end
         if (accept) begin
            pc_reg       <= i_pc;
            opcode_reg   <= i_instr[6:0];
            funct3_reg   <= i_instr[14:12];
            funct7_reg   <= i_instr[31:25];
            rd_reg       <= i_instr[11:7];
            rd_we_reg    <= rd_we_next;
            rs1_addr_reg <= i_instr[19:15];
            rs2_addr_reg <= i_instr[24:20];
            imm_reg      <= imm_next;
            illegal_reg  <= !legal;
         end
      end
   end

   assign raddr[0]     = i_instr[19:15];
   assign raddr[1]     = i_instr[24:20];
   assign held_addr[0] = rs1_addr_reg;
   assign held_addr[1] = rs2_addr_reg;
   assign rdata[0]     = i_rs1_rdata;
   assign rdata[1]     = i_rs2_rdata;

   // Per-operand bypass: catch the write the register file misses during the read
   // cycle, and any write landing on the held source while execute is stalled.
   for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic            hit_new;
      logic            hit_held;
      logic            ovr_flag_reg;
      logic [XLEN-1:0] ovr_value_reg;

      assign hit_new  = i_rd_wvalid && (i_rd_waddr == raddr[gi]) && (raddr[gi] != 5'd0);
      assign hit_held = i_rd_wvalid && (i_rd_waddr == held_addr[gi]) && (held_addr[gi] != 5'd0);

      always_ff @(posedge clk) begin
         if (rst) begin
            ovr_flag_reg  <= 1'b0;
            ovr_value_reg <= '0;
         end else if (accept) begin
            ovr_flag_reg  <= hit_new;
            ovr_value_reg <= i_rd_wdata;
         end else if (stall && hit_held) begin
            ovr_flag_reg  <= 1'b1;
            ovr_value_reg <= i_rd_wdata;
         end
      end

      assign operand[gi] = (held_addr[gi] == 5'd0) ? '0 :
                           ovr_flag_reg            ? ovr_value_reg : rdata[gi];
   end

   assign o_valid    = valid_reg;
   assign o_pc       = pc_reg;
   assign o_opcode   = opcode_reg;
   assign o_funct3   = funct3_reg;
   assign o_funct7   = funct7_reg;
   assign o_rd       = rd_reg;
   assign o_rd_we    = rd_we_reg;
   assign o_rs1_addr = rs1_addr_reg;
   assign o_rs2_addr = rs2_addr_reg;
   assign o_rs1_data = operand[0];
   assign o_rs2_data = operand[1];
   assign o_imm      = imm_reg;
   assign o_illegal  = illegal_reg;
endmodule
